servo_motion_seq: RTL and testbench
===================================

# servo_motion_seq

Command sequencer for one continuous-rotation servo channel. It accepts queued motion commands (target pulse width plus hold duration) over a valid/ready handshake. It slew-limits the pulse width once per 50 Hz frame and drives the `divisor` input of the servo PWM generator. It sits between the host/control logic and the PWM block, and shares `clk_in`/`rst_in` with that block so both frame counters stay aligned.

## Interface
- `FRAME_CYCLES`, default 1_966_080: cycles per PWM frame (98.304 MHz / 50 Hz).
- `STOP_DIV`, default 147_456: neutral pulse width (1.5 ms, servo stopped).
- `MIN_DIV`, default 98_304: lowest legal pulse width (1.0 ms).
- `MAX_DIV`, default 196_608: highest legal pulse width (2.0 ms).
- `STEP`, default 4_096: maximum change of `divisor` per frame.
- `DEPTH`, default 4: command queue depth (power of 2).
- `clk_in` — in, 1: system clock, 98.304 MHz. Only clock.
- `rst_in` — in, 1: reset, asynchronous, active-high.
- `cmd_valid` — in, 1: command offered.
- `cmd_ready` — out, 1: queue can accept.
- `cmd_div` — in, 22: target pulse width in cycles.
- `cmd_frames` — in, 8: frames to hold at target.
- `abort_in` — in, 1: single-cycle pulse; flush and stop.
- `divisor` — out, 22: pulse width to PWM block.
- `frame_tick` — out, 1: one-cycle pulse on the last cycle of each frame.
- `busy` — out, 1: state ≠ IDLE or `divisor` ≠ `STOP_DIV`.
- `queue_count` — out, $clog2(DEPTH)+1: queued commands.

## Operation
- Frame counter counts 0..`FRAME_CYCLES`-1 and wraps.
- `frame_tick` = 1 exactly when the counter equals `FRAME_CYCLES`-1.
- Enqueue on `cmd_valid && cmd_ready`.
- `cmd_div` is clamped to [`MIN_DIV`, `MAX_DIV`] before it is stored.
- `cmd_ready` = (`queue_count` < `DEPTH`) && !`abort_in`.
- All state and `divisor` changes happen only on `frame_tick` cycles, except enqueue and abort.
- Slew rule:
  - `divisor` moves toward the current target by min(`STEP`, |target − `divisor`|).
  - Difference is computed as a 23-bit signed value; no overshoot.
- States:
  - IDLE: target = `STOP_DIV`. On `frame_tick` with queue non-empty: pop the command, load the target, go to RAMP. The same tick also applies one slew step.
  - RAMP: on `frame_tick`, apply the slew step. If the post-step `divisor` equals the target, load `hold_cnt` = `cmd_frames` and go to HOLD.
  - HOLD: on `frame_tick`:
    - If `hold_cnt` ≠ 0, decrement it.
    - Else, if the queue is non-empty, pop and go to RAMP, applying the first slew step on the same tick.
    - Else go to IDLE, which then ramps back to `STOP_DIV`.
- `cmd_frames` = 0: leave HOLD on the first tick after arrival.
- Abort:
  - Empty the queue next cycle.
  - Force state to IDLE.
  - `divisor` ramps to `STOP_DIV` at `STEP`/frame; there is no jump.
  - Abort wins over a simultaneous enqueue (which is dropped) and over a simultaneous `frame_tick` pop.
- Simultaneous push and pop on one cycle: `queue_count` unchanged. A full queue stays not-ready that cycle.
- Reset values:
  - `divisor` = `STOP_DIV`, `frame_tick` = 0, `busy` = 0, `queue_count` = 0.
  - `cmd_ready` = 1 once `rst_in` is low.
  - Frame counter = 0, state = IDLE, `hold_cnt` = 0.
- Reset mid-ramp or mid-hold: everything returns to reset values immediately and asynchronously.

## Timing
- `divisor` is registered. A value computed on the `frame_tick` cycle is visible from the next cycle, i.e. frame-counter 0, so each PWM frame uses one constant width.
- Enqueue-to-queue latency: 1 cycle. `queue_count` updates the cycle after the handshake.
- Command start latency: at the next `frame_tick` after enqueue. Worst case `FRAME_CYCLES` cycles.
- Ramp duration: ceil(|Δ|/`STEP`) frames.
- Abort-to-stop: ceil(|`divisor` − `STOP_DIV`|/`STEP`) frames.

## Structure
- Package `servo_pkg`:
  - `FRAME_CYCLES`, `STOP_DIV`, `MIN_DIV`, `MAX_DIV` constants.
  - `servo_cmd_t` struct {`div`[21:0], `frames`[7:0]}.
  - State enum `servo_seq_state_e` {IDLE, RAMP, HOLD}.
- Sub-module `servo_cmd_fifo`:
  - Synchronous FIFO of `servo_cmd_t`, `DEPTH` entries.
  - Push/pop/flush ports, count output.
  - Asynchronous reset.
- Top level contains the frame counter, FSM, slew arithmetic and clamp.

## Test plan
All scenarios use `FRAME_CYCLES`=100 and `STEP`=4_096.
- Reset during HOLD: `rst_in` pulse → `divisor`=147_456, `queue_count`=0, `busy`=0 on the same cycle; `frame_tick` next at cycle 99 after release.
- Single command, `cmd_div`=163_840, `cmd_frames`=2:
  - `divisor` steps 151_552, 155_648, 159_744, 163_840 on consecutive frames.
  - Holds 163_840 for 3 frame starts (arrival frame + 2 held frames).
  - Then ramps back to 147_456 and `busy` drops.
- Clamp: `cmd_div`=300_000 → target 196_608; `cmd_div`=1_000 → target 98_304; no overshoot on the final step (odd Δ=1_000 finishes with a 1_000 step).
- Full queue: 5 back-to-back pushes while IDLE mid-frame → first 4 accepted, `cmd_ready`=0 on the 5th; at `frame_tick` a pop restores `cmd_ready`=1 next cycle.
- Abort at `divisor`=180_224 with 3 queued commands → `queue_count`=0 next cycle; an enqueue on the abort cycle is not stored; `divisor` reaches 147_456 after 8 frames.
- Back-to-back commands with `cmd_frames`=0: the second command's first slew step occurs on the frame immediately after the first target is reached; there is no IDLE frame between them.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types, default constants and arithmetic helpers for the servo sequencer.
package servo_pkg;

   localparam int FRAME_CYCLES = 1_966_080;
   localparam int STOP_DIV     = 147_456;
   localparam int MIN_DIV      = 98_304;
   localparam int MAX_DIV      = 196_608;

   typedef struct packed {
      logic [21:0] div;
      logic [7:0]  frames;
   } servo_cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      HOLD = 2'd2
   } servo_seq_state_e;

   // Restrict a requested pulse width to the legal servo range.
   function automatic logic [21:0] clamp_div(input logic [21:0] d,
                                             input logic [21:0] lo,
                                             input logic [21:0] hi);
      logic [21:0] r;
      if (d < lo)
         r = lo;
      else if (d > hi)
         r = hi;
      else
         r = d;
      return r;
   endfunction

   // One slew step from cur toward tgt, never overshooting the target.
   function automatic logic [21:0] slew_step(input logic [21:0] cur,
                                             input logic [21:0] tgt,
                                             input logic [21:0] step);
      logic signed [22:0] diff;
      logic signed [22:0] lim;
      logic [21:0]        r;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      lim  = $signed({1'b0, step});
      if (diff > lim)
         r = cur + step;
      else if (diff < -lim)
         r = cur - step;
      else
         r = tgt;
      return r;
   endfunction

endpackage

// File: rtl/servo_cmd_fifo.sv
// Small show-ahead command queue: head entry is always visible, pop advances it.
module servo_cmd_fifo
   import servo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   push,
   input  servo_cmd_t             push_data,
   input  logic                   pop,
   input  logic                   flush,
   output servo_cmd_t             head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   servo_cmd_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Flush dominates; push only with room, pop only with data.
   always_comb begin
      do_push = push && (count != CW'(DEPTH)) && !flush;
      do_pop  = pop && (count != '0) && !flush;
      head    = mem[rd_ptr];
   end

   // Storage array, written at the tail.
   always_ff @(posedge clk_in) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/servo_motion_seq.sv
// Servo command sequencer: queues motion commands and slew-limits the PWM
// pulse width once per frame, holding each target for the requested frames.
module servo_motion_seq #(
   parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES,
   parameter int STOP_DIV     = servo_pkg::STOP_DIV,
   parameter int MIN_DIV      = servo_pkg::MIN_DIV,
   parameter int MAX_DIV      = servo_pkg::MAX_DIV,
   parameter int STEP         = 4_096,
   parameter int DEPTH        = 4
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [21:0]            cmd_div,
   input  logic [7:0]             cmd_frames,
   input  logic                   abort_in,
   output logic [21:0]            divisor,
   output logic                   frame_tick,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] queue_count
);

   import servo_pkg::*;

   localparam int                CNT_W  = $clog2(FRAME_CYCLES);
   localparam int                CW     = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0]  LAST   = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [21:0]       STOP_V = 22'(STOP_DIV);
   localparam logic [21:0]       MIN_V  = 22'(MIN_DIV);
   localparam logic [21:0]       MAX_V  = 22'(MAX_DIV);
   localparam logic [21:0]       STEP_V = 22'(STEP);

   logic [CNT_W-1:0]  frame_cnt;
   servo_seq_state_e  state_reg;
   servo_seq_state_e  state_next;
   logic [21:0]       target_reg;
   logic [21:0]       target_next;
   logic [7:0]        frames_reg;
   logic [7:0]        frames_next;
   logic [7:0]        hold_reg;
   logic [7:0]        hold_next;
   logic [21:0]       divisor_reg;
   logic [21:0]       divisor_next;
   logic [21:0]       ramp_div;
   logic              pop;
   logic              push;
   logic              queue_nonempty;
   servo_cmd_t        push_data;
   servo_cmd_t        head;

   servo_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (abort_in),
      .head      (head),
      .count     (queue_count)
   );

   // Free-running frame counter, 0..FRAME_CYCLES-1.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         frame_cnt <= '0;
      else if (frame_tick)
         frame_cnt <= '0;
      else
         frame_cnt <= frame_cnt + 1'b1;
   end

   // Sequencer state register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Motion datapath registers: target, hold bookkeeping and output width.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         target_reg  <= STOP_V;
         frames_reg  <= '0;
         hold_reg    <= '0;
         divisor_reg <= STOP_V;
      end else begin
         target_reg  <= target_next;
         frames_reg  <= frames_next;
         hold_reg    <= hold_next;
         divisor_reg <= divisor_next;
      end
   end

   // Next-state logic; the slew step always heads toward the target chosen
   // on this tick, so a pop or a return to IDLE moves divisor immediately.
   always_comb begin
      state_next   = state_reg;
      target_next  = target_reg;
      frames_next  = frames_reg;
      hold_next    = hold_reg;
      pop          = 1'b0;
      ramp_div     = slew_step(divisor_reg, target_reg, STEP_V);
      if (abort_in) begin
         state_next  = IDLE;
         target_next = STOP_V;
         hold_next   = '0;
      end else if (frame_tick) begin
         unique case (state_reg)
            IDLE: begin
               target_next = STOP_V;
               if (queue_nonempty) begin
                  pop         = 1'b1;
                  target_next = head.div;
                  frames_next = head.frames;
                  state_next  = RAMP;
               end
            end
            RAMP: begin
               if (ramp_div == target_reg) begin
                  hold_next  = frames_reg;
                  state_next = HOLD;
               end
            end
            HOLD: begin
               if (hold_reg != '0) begin
                  hold_next = hold_reg - 1'b1;
               end else if (queue_nonempty) begin
                  pop         = 1'b1;
                  target_next = head.div;
                  frames_next = head.frames;
                  state_next  = RAMP;
               end else begin
                  target_next = STOP_V;
                  state_next  = IDLE;
               end
            end
            default: begin
               target_next = STOP_V;
               state_next  = IDLE;
            end
         endcase
      end
      divisor_next = frame_tick ? slew_step(divisor_reg, target_next, STEP_V)
                                : divisor_reg;
   end

   // Outputs and handshake; abort blocks enqueue on its own cycle.
   always_comb begin
      frame_tick     = (frame_cnt == LAST);
      queue_nonempty = (queue_count != '0);
      cmd_ready      = (queue_count < CW'(DEPTH)) && !abort_in;
      push           = cmd_valid && cmd_ready;
      push_data.div    = clamp_div(cmd_div, MIN_V, MAX_V);
      push_data.frames = cmd_frames;
      divisor        = divisor_reg;
      busy           = (state_reg != IDLE) || (divisor_reg != STOP_V);
   end

endmodule

// File: tb/tb_servo_motion_seq.sv
// Directed bench for servo_motion_seq with a 100-cycle frame.
module tb_servo_motion_seq;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [21:0] cmd_div;
   logic [7:0]  cmd_frames;
   logic        abort_in;
   logic [21:0] divisor;
   logic        frame_tick;
   logic        busy;
   logic [2:0]  queue_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   servo_motion_seq #(
      .FRAME_CYCLES (100),
      .STEP         (4096)
   ) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_div     (cmd_div),
      .cmd_frames  (cmd_frames),
      .abort_in    (abort_in),
      .divisor     (divisor),
      .frame_tick  (frame_tick),
      .busy        (busy),
      .queue_count (queue_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Advance to the negedge right after the next frame_tick edge.
   task automatic wait_tick(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (frame_tick) begin
            found = 1'b1;
            break;
         end
         @(negedge clk_in);
      end
      if (!found)
         check({tag, "_timeout"}, 32'(found), 32'd1);
      @(negedge clk_in);
   endtask

   task automatic push(input logic [21:0] d, input logic [7:0] f);
      cmd_valid  = 1'b1;
      cmd_div    = d;
      cmd_frames = f;
      @(negedge clk_in);
      cmd_valid  = 1'b0;
   endtask

   initial begin
      rst_in     = 1'b1;
      cmd_valid  = 1'b0;
      cmd_div    = '0;
      cmd_frames = '0;
      abort_in   = 1'b0;

      // Reset state
      cyc(3);
      check("rst_divisor", 32'(divisor), 32'd147456);
      check("rst_qcount", 32'(queue_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tick", 32'(frame_tick), 32'd0);
      rst_in = 1'b0;
      #1;
      check("rst_ready", 32'(cmd_ready), 32'd1);
      cyc(98);
      check("first_tick_early", 32'(frame_tick), 32'd0);
      cyc(1);
      check("first_tick", 32'(frame_tick), 32'd1);
      @(negedge clk_in);

      // Single command 163840 holding 2 frames
      cyc(10);
      check("a_ready", 32'(cmd_ready), 32'd1);
      push(22'd163840, 8'd2);
      check("a_qcount", 32'(queue_count), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         wait_tick("a_ramp");
         check("a_ramp_div", 32'(divisor), 32'(147456 + 4096 * k));
      end
      check("a_busy", 32'(busy), 32'd1);
      check("a_qempty", 32'(queue_count), 32'd0);
      cyc(50);
      check("a_midframe_const", 32'(divisor), 32'd163840);
      for (int k = 0; k < 2; k++) begin
         wait_tick("a_hold");
         check("a_hold_div", 32'(divisor), 32'd163840);
      end
      for (int k = 1; k <= 4; k++) begin
         wait_tick("a_back");
         check("a_back_div", 32'(divisor), 32'(163840 - 4096 * k));
      end
      check("a_idle_busy", 32'(busy), 32'd0);

      // Clamp high, clamp low, then an odd 1000-cycle move
      cyc(10);
      push(22'd300000, 8'd0);
      push(22'd1000, 8'd0);
      push(22'd99304, 8'd0);
      check("b_qcount", 32'(queue_count), 32'd3);
      for (int k = 1; k <= 12; k++)
         wait_tick("b_up");
      check("b_clamp_hi", 32'(divisor), 32'd196608);
      wait_tick("b_pop2");
      check("b_no_overshoot_hi", 32'(divisor), 32'd192512);
      for (int k = 2; k <= 24; k++)
         wait_tick("b_down");
      check("b_clamp_lo", 32'(divisor), 32'd98304);
      wait_tick("b_pop3");
      check("b_odd_step", 32'(divisor), 32'd99304);
      wait_tick("b_arrive3");
      check("b_odd_hold", 32'(divisor), 32'd99304);
      wait_tick("b_leave3");
      check("b_return_first", 32'(divisor), 32'd103400);
      for (int k = 0; k < 11; k++)
         wait_tick("b_return");
      check("b_return_stop", 32'(divisor), 32'd147456);
      check("b_busy", 32'(busy), 32'd0);

      // Full queue: five back-to-back pushes mid-frame
      cyc(20);
      for (int k = 0; k < 5; k++) begin
         cmd_valid  = 1'b1;
         cmd_div    = (k == 0) ? 22'd180224 : 22'd196608;
         cmd_frames = (k == 0) ? 8'd20 : 8'd0;
         check("c_ready", 32'(cmd_ready), (k < 4) ? 32'd1 : 32'd0);
         @(negedge clk_in);
      end
      cmd_valid = 1'b0;
      check("c_full_count", 32'(queue_count), 32'd4);
      for (int i = 0; i < 200; i++) begin
         if (frame_tick)
            break;
         @(negedge clk_in);
      end
      check("c_tick_seen", 32'(frame_tick), 32'd1);
      check("c_ready_on_tick", 32'(cmd_ready), 32'd0);
      @(negedge clk_in);
      check("c_ready_after_pop", 32'(cmd_ready), 32'd1);
      check("c_count_after_pop", 32'(queue_count), 32'd3);
      check("c_first_step", 32'(divisor), 32'd151552);
      for (int k = 2; k <= 8; k++)
         wait_tick("c_ramp");
      check("c_reach", 32'(divisor), 32'd180224);
      wait_tick("c_hold");
      check("c_hold_div", 32'(divisor), 32'd180224);
      check("c_hold_count", 32'(queue_count), 32'd3);

      // Abort with three queued commands and a simultaneous enqueue
      cyc(30);
      abort_in   = 1'b1;
      cmd_valid  = 1'b1;
      cmd_div    = 22'd1000;
      cmd_frames = 8'd0;
      #1;
      check("d_ready_abort", 32'(cmd_ready), 32'd0);
      @(negedge clk_in);
      abort_in  = 1'b0;
      cmd_valid = 1'b0;
      check("d_flushed", 32'(queue_count), 32'd0);
      check("d_no_jump", 32'(divisor), 32'd180224);
      check("d_busy", 32'(busy), 32'd1);
      for (int k = 1; k <= 8; k++) begin
         wait_tick("d_stop");
         check("d_stop_div", 32'(divisor), 32'(180224 - 4096 * k));
      end
      check("d_busy_done", 32'(busy), 32'd0);
      wait_tick("d_settled");
      check("d_settled_div", 32'(divisor), 32'd147456);

      // Back-to-back zero-hold commands: no IDLE frame between them
      cyc(10);
      push(22'd155648, 8'd0);
      push(22'd163840, 8'd0);
      wait_tick("e_t1");
      check("e_t1_div", 32'(divisor), 32'd151552);
      wait_tick("e_t2");
      check("e_t2_div", 32'(divisor), 32'd155648);
      wait_tick("e_t3");
      check("e_second_step", 32'(divisor), 32'd159744);
      wait_tick("e_t4");
      check("e_t4_div", 32'(divisor), 32'd163840);
      wait_tick("e_t5");
      check("e_leave", 32'(divisor), 32'd159744);
      for (int k = 0; k < 3; k++)
         wait_tick("e_back");
      check("e_stop", 32'(divisor), 32'd147456);
      check("e_busy", 32'(busy), 32'd0);

      // Reset during HOLD
      cyc(10);
      push(22'd163840, 8'd50);
      push(22'd196608, 8'd0);
      for (int k = 0; k < 5; k++)
         wait_tick("f_ramp");
      check("f_hold_div", 32'(divisor), 32'd163840);
      check("f_hold_count", 32'(queue_count), 32'd1);
      cyc(40);
      rst_in = 1'b1;
      #1;
      check("f_rst_divisor", 32'(divisor), 32'd147456);
      check("f_rst_qcount", 32'(queue_count), 32'd0);
      check("f_rst_busy", 32'(busy), 32'd0);
      cyc(2);
      rst_in = 1'b0;
      cyc(98);
      check("f_tick_early", 32'(frame_tick), 32'd0);
      cyc(1);
      check("f_tick", 32'(frame_tick), 32'd1);
      @(negedge clk_in);
      check("f_after_div", 32'(divisor), 32'd147456);
      check("f_after_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
